// File: rtl/rx_align_pkg.sv
// Shared types and defaults for the rx DDR word-alignment controller.
// Lane state encoding, counter-width helper and default parameter values.
package rx_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } lane_state_e;

  localparam int unsigned DEF_S             = 8;
  localparam int unsigned DEF_D             = 4;
  localparam logic [7:0]  DEF_TRAIN_WORD    = 8'h3C;
  localparam int unsigned DEF_MATCH_COUNT   = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_MAX_SLIPS     = 2 * DEF_S;
  localparam int unsigned DEF_LOSS_COUNT    = 4;

  // Bits needed to hold every value in 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return unsigned'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/rx_lane_align.sv
// Single-lane word-alignment FSM: hunts for the training word, slips, settles, locks.
// Loss-of-lock handling selected by RX_ALIGN_AUTO_RETRAIN_EN (re-hunt) or default (fail).
module rx_lane_align
  import rx_align_pkg::*;
#(
  parameter int unsigned  S             = DEF_S,
  parameter logic [S-1:0] TRAIN_WORD    = DEF_TRAIN_WORD,
  parameter int unsigned  MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int unsigned  SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned  MAX_SLIPS     = DEF_MAX_SLIPS,
  parameter int unsigned  LOSS_COUNT    = DEF_LOSS_COUNT
) (
  input  logic         i_gclk,
  input  logic         i_reset,
  input  logic         i_train_en,
  input  logic         i_retrain,
  input  logic [S-1:0] i_word,
  output logic         o_bitslip,
  output logic         o_locked,
  output logic         o_fail
);

  localparam int unsigned MW = cnt_w(MATCH_COUNT);
  localparam int unsigned SW = cnt_w(MAX_SLIPS);
  localparam int unsigned TW = cnt_w(SETTLE_CYCLES);
  localparam int unsigned EW = cnt_w(LOSS_COUNT);

  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);
  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYCLES);
  localparam logic [EW-1:0] LOSS_LAST  = EW'(LOSS_COUNT - 1);

  lane_state_e   r_state, w_state_nx;
  logic [MW-1:0] r_match, w_match_nx;
  logic [SW-1:0] r_slip, w_slip_nx;
  logic [TW-1:0] r_settle, w_settle_nx;
  logic [EW-1:0] r_err, w_err_nx;
  logic          r_bitslip, r_locked, r_fail;
  logic          w_hit;

  assign w_hit = (i_word == TRAIN_WORD);

  always_comb begin
    w_state_nx  = r_state;
    w_match_nx  = r_match;
    w_slip_nx   = r_slip;
    w_settle_nx = r_settle;
    w_err_nx    = r_err;
    if (i_retrain) begin
      w_state_nx  = ST_IDLE;
      w_match_nx  = '0;
      w_slip_nx   = '0;
      w_settle_nx = '0;
      w_err_nx    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_train_en) begin
            w_state_nx = ST_HUNT;
            w_match_nx = '0;
            w_slip_nx  = '0;
          end
        end
        // With training off the lane parks here without comparing or slipping.
        ST_HUNT: begin
          if (i_train_en) begin
            if (w_hit) begin
              w_match_nx = r_match + 1'b1;
              if (r_match == MATCH_LAST) begin
                w_state_nx = ST_LOCKED;
                w_err_nx   = '0;
              end
            end else begin
              w_match_nx = '0;
              w_state_nx = (r_slip < SLIP_MAX) ? ST_SLIP : ST_FAIL;
            end
          end
        end
        ST_SLIP: begin
          if (r_slip != SLIP_MAX) w_slip_nx = r_slip + 1'b1;
          w_settle_nx = '0;
          w_state_nx  = ST_SETTLE;
        end
        ST_SETTLE: begin
          w_settle_nx = r_settle + 1'b1;
          if (w_settle_nx == SETTLE_END) begin
            w_state_nx  = ST_HUNT;
            w_match_nx  = '0;
            w_settle_nx = '0;
          end
        end
        ST_LOCKED: begin
          if (!i_train_en || w_hit) begin
            w_err_nx = '0;
          end else if (r_err == LOSS_LAST) begin
            w_err_nx = '0;
`ifdef RX_ALIGN_AUTO_RETRAIN_EN
            w_state_nx = ST_HUNT;
            w_slip_nx  = '0;
            w_match_nx = '0;
`else
            w_state_nx = ST_FAIL;
`endif
          end else begin
            w_err_nx = r_err + 1'b1;
          end
        end
        ST_FAIL: w_state_nx = ST_FAIL;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they align with r_state.
  always_ff @(posedge i_gclk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_match   <= '0;
      r_slip    <= '0;
      r_settle  <= '0;
      r_err     <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_match   <= w_match_nx;
      r_slip    <= w_slip_nx;
      r_settle  <= w_settle_nx;
      r_err     <= w_err_nx;
      r_bitslip <= (w_state_nx == ST_SLIP);
      r_locked  <= (w_state_nx == ST_LOCKED);
      r_fail    <= (w_state_nx == ST_FAIL);
    end
  end

  assign o_bitslip = r_bitslip;
  assign o_locked  = r_locked;
  assign o_fail    = r_fail;

endmodule

// File: rtl/rx_ddr_align_ctrl.sv
// Word-alignment training controller for a D-lane 1:S DDR LVDS receiver.
// Optional macro RX_ALIGN_AUTO_RETRAIN_EN: lost lock re-hunts instead of failing the lane.
module rx_ddr_align_ctrl
  import rx_align_pkg::*;
#(
  parameter int unsigned  S             = DEF_S,
  parameter int unsigned  D             = DEF_D,
  parameter int unsigned  DS            = (D * S) - 1,
  parameter logic [S-1:0] TRAIN_WORD    = DEF_TRAIN_WORD,
  parameter int unsigned  MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int unsigned  SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned  MAX_SLIPS     = 2 * S,
  parameter int unsigned  LOSS_COUNT    = DEF_LOSS_COUNT
) (
  input  logic          gclk,
  input  logic          reset,
  input  logic [DS:0]   rxd,
  input  logic          train_en,
  input  logic          retrain,
  output logic [D-1:0]  bitslip,
  output logic [D-1:0]  lane_locked,
  output logic [D-1:0]  lane_fail,
  output logic          all_locked,
  output logic [DS:0]   dataout,
  output logic          dataout_valid
);

  logic          r_all_locked;
  logic          r_valid;
  logic [DS:0]   r_data;

  for (genvar gi = 0; gi < D; gi++) begin : g_lane
    rx_lane_align #(
      .S             (S),
      .TRAIN_WORD    (TRAIN_WORD),
      .MATCH_COUNT   (MATCH_COUNT),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .MAX_SLIPS     (MAX_SLIPS),
      .LOSS_COUNT    (LOSS_COUNT)
    ) u_lane (
      .i_gclk     (gclk),
      .i_reset    (reset),
      .i_train_en (train_en),
      .i_retrain  (retrain),
      .i_word     (rxd[gi*S +: S]),
      .o_bitslip  (bitslip[gi]),
      .o_locked   (lane_locked[gi]),
      .o_fail     (lane_fail[gi])
    );
  end

  // dataout_valid shares all_locked's input so it is never high while all_locked is low.
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_all_locked <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
    end else begin
      r_all_locked <= &lane_locked;
      r_valid      <= &lane_locked;
      r_data       <= rxd;
    end
  end

  assign all_locked    = r_all_locked;
  assign dataout_valid = r_valid;
  assign dataout       = r_data;

endmodule

// File: tb/tb_rx_ddr_align_ctrl.sv
// Directed self-checking bench for rx_ddr_align_ctrl (default parameters).
// Honours RX_ALIGN_AUTO_RETRAIN_EN when choosing loss-of-lock expectations.
module tb_rx_ddr_align_ctrl;

  logic        gclk = 1'b0;
  logic        reset;
  logic [31:0] rxd;
  logic        train_en;
  logic        retrain;
  logic [3:0]  bitslip;
  logic [3:0]  lane_locked;
  logic [3:0]  lane_fail;
  logic        all_locked;
  logic [31:0] dataout;
  logic        dataout_valid;

  int total = 0;
  int bad   = 0;

`ifdef RX_ALIGN_AUTO_RETRAIN_EN
  localparam logic [3:0] EXP_LOSS_FAIL = 4'h0;
`else
  localparam logic [3:0] EXP_LOSS_FAIL = 4'h1;
`endif

  always #5 gclk = ~gclk;

  rx_ddr_align_ctrl #(
    .S (8),
    .D (4)
  ) dut (
    .gclk          (gclk),
    .reset         (reset),
    .rxd           (rxd),
    .train_en      (train_en),
    .retrain       (retrain),
    .bitslip       (bitslip),
    .lane_locked   (lane_locked),
    .lane_fail     (lane_fail),
    .all_locked    (all_locked),
    .dataout       (dataout),
    .dataout_valid (dataout_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge gclk);
  endtask

  task automatic setw(input int lane, input logic [7:0] w);
    rxd[lane*8 +: 8] = w;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [15:0] t;
    t = {w, w} << n;
    return t[15:8];
  endfunction

  logic [31:0] pay [4];
  int          pulses [4];
  int          npulse, lock2_at, lock0_at, other_slips, dbl, fail_at, last_pulse, all_seen;
  logic        prev_slip;

  initial begin
    pay[0] = 32'h12345678;
    pay[1] = 32'hA5A55A5A;
    pay[2] = 32'hFFFF0000;
    pay[3] = 32'h0F1E2D3C;

    reset = 1'b1; train_en = 1'b0; retrain = 1'b0; rxd = {4{8'h3C}};
    repeat (3) step();
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", lane_locked, 0);
    chk("rst_fail", lane_fail, 0);
    chk("rst_all", all_locked, 0);
    chk("rst_valid", dataout_valid, 0);
    chk("rst_data", dataout, 0);

    // Clean training: lock after 9 edges, all_locked one edge later.
    reset = 1'b0; train_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t1_noslip", bitslip, 0);
      if (k == 8) chk("t1_lock_early", lane_locked, 0);
      if (k == 9) begin
        chk("t1_lock", lane_locked, 4'hF);
        chk("t1_all_lag", all_locked, 0);
      end
      if (k == 10) begin
        chk("t1_all", all_locked, 1);
        chk("t1_valid", dataout_valid, 1);
      end
    end

    // Payload with train_en low: data passes with one-cycle latency, lock held.
    train_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rxd = pay[i];
      step();
      chk("pay_data", dataout, pay[i]);
      chk("pay_lock", lane_locked, 4'hF);
      chk("pay_valid", dataout_valid, 1);
    end
    rxd = {4{8'h3C}}; train_en = 1'b1;
    step(); step();

    // Three corrupt words on lane 0: lock kept.
    setw(0, 8'h00);
    repeat (3) step();
    chk("loss3_keep", lane_locked, 4'hF);
    setw(0, 8'h3C);
    step();
    chk("loss3_nofail", lane_fail, 0);

    // Four corrupt words: lock lost.
    setw(0, 8'h00);
    repeat (3) step();
    chk("loss4_pre", lane_locked, 4'hF);
    step();
    chk("loss4_locked", lane_locked, 4'hE);
    chk("loss4_fail", lane_fail, EXP_LOSS_FAIL);
    chk("loss4_all_lag", all_locked, 1);
    step();
    chk("loss4_all", all_locked, 0);
    chk("loss4_valid", dataout_valid, 0);

    // Retrain recovers all lanes.
    setw(0, 8'h3C);
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    chk("rt_locked", lane_locked, 0);
    chk("rt_fail", lane_fail, 0);
    chk("rt_slip", bitslip, 0);
    repeat (8) step();
    chk("rt_relock_early", lane_locked, 0);
    step();
    chk("rt_relock", lane_locked, 4'hF);

    // Lane 2 rotated by 3 bits; each observed slip rotates it back by one.
    train_en = 1'b0; retrain = 1'b1;
    step();
    retrain = 1'b0;
    rxd = {4{8'h3C}};
    setw(2, rotl(8'h3C, 3));
    train_en = 1'b1;
    npulse = 0; lock2_at = 0; lock0_at = 0; other_slips = 0; dbl = 0; prev_slip = 1'b0;
    for (int s = 1; s <= 80; s++) begin
      step();
      if (bitslip[2]) begin
        if (npulse < 4) pulses[npulse] = s;
        npulse++;
        if (prev_slip) dbl++;
        if (npulse <= 3) setw(2, rotl(8'h3C, 3 - npulse));
      end
      prev_slip = bitslip[2];
      if ((bitslip & 4'b1011) != 0) other_slips++;
      if (lane_locked[2] && lock2_at == 0) lock2_at = s;
      if (lane_locked[0] && lock0_at == 0) lock0_at = s;
    end
    chk("rot_npulse", npulse, 3);
    chk("rot_p0", pulses[0], 2);
    chk("rot_p1", pulses[1], 20);
    chk("rot_p2", pulses[2], 38);
    chk("rot_back2back", dbl, 0);
    chk("rot_other_slip", other_slips, 0);
    chk("rot_lock2_at", lock2_at, 63);
    chk("rot_lock0_at", lock0_at, 9);
    chk("rot_all", all_locked, 1);

    // Lane 1 stuck at zero: 16 slips then sticky failure.
    train_en = 1'b0; retrain = 1'b1;
    step();
    retrain = 1'b0;
    rxd = {4{8'h3C}};
    setw(1, 8'h00);
    train_en = 1'b1;
    npulse = 0; last_pulse = 0; fail_at = 0; all_seen = 0;
    for (int s = 1; s <= 320; s++) begin
      step();
      if (bitslip[1]) begin
        npulse++;
        last_pulse = s;
      end
      if (lane_fail[1] && fail_at == 0) fail_at = s;
      if (all_locked) all_seen++;
    end
    chk("zero_npulse", npulse, 16);
    chk("zero_last", last_pulse, 272);
    chk("zero_fail_at", fail_at, 290);
    chk("zero_fail", lane_fail, 4'h2);
    chk("zero_locked", lane_locked, 4'hD);
    chk("zero_all", all_seen, 0);

    // Retrain while lane 3 is settling after its first slip.
    train_en = 1'b0; retrain = 1'b1;
    step();
    retrain = 1'b0;
    rxd = {4{8'h3C}};
    setw(3, 8'h00);
    train_en = 1'b1;
    repeat (10) step();
    chk("rs_partial", lane_locked, 4'h7);
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    chk("rs_slip", bitslip, 0);
    chk("rs_locked", lane_locked, 0);
    chk("rs_fail", lane_fail, 0);
    setw(3, 8'h3C);
    repeat (8) step();
    chk("rs_relock_early", lane_locked, 0);
    step();
    chk("rs_relock", lane_locked, 4'hF);

    // Reset on the edge that would enter SLIP suppresses the pulse.
    setw(0, 8'h00);
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rsl_slip", bitslip, 0);
    chk("rsl_locked", lane_locked, 0);
    chk("rsl_fail", lane_fail, 0);
    chk("rsl_all", all_locked, 0);
    chk("rsl_data", dataout, 0);
    reset = 1'b0;
    step();
    chk("rsl_hunt", bitslip, 0);
    step();
    chk("rsl_resume", bitslip, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
